match_sequencer: RTL and testbench

//  Match-level controller that sequences the scoring datapath (ball_count / team_score / score_comparator).

---
 rtl/match_sequencer.sv | 158 +++++++++++++++
 tb/tb_match_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// match_sequencer: toss/innings/break sequencing, over tracking and bowler rotation for the scoring datapath
module match_sequencer #(
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS = 20,
  parameter int NUM_BOWLERS = 5,
  parameter int MAX_OVERS_BOWLER = 4,
  parameter int BREAK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       toss_winner,
  input  logic       toss_choice,
  input  logic       delivery,
  input  logic       innings_over,
  input  logic       game_over,
  output logic       team,
  output logic       play,
  output logic [2:0] bowler_id,
  output logic [4:0] over_num,
  output logic [2:0] ball_in_over,
  output logic       innings_break,
  output logic       match_done,
  output logic       sched_err
);
  localparam int QW = $clog2(MAX_OVERS_BOWLER + 1);
  localparam int CW = $clog2(BREAK_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, TOSS, INN1, BRK, INN2, DONE} state_t;
  state_t          state_q, state_d;
  logic            first_q, first_d, team_q, team_d, play_q, play_d;
  logic            brk_q, brk_d, done_q, done_d, err_q, err_d;
  logic [2:0]      bowler_q, bowler_d, ball_q, ball_d, nxt_id, cand;
  logic [4:0]      over_q, over_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [QW-1:0]   quota_q [NUM_BOWLERS];
  logic [QW-1:0]   quota_d [NUM_BOWLERS];
  logic            nxt_ok, in_inn, over_end, inn_end_overs, toss_team;
  always_comb begin
    nxt_ok = 1'b0;
    nxt_id = bowler_q;
    cand = '0;
    for (int k = NUM_BOWLERS - 1; k >= 1; k--) begin
      cand = 3'((int'(bowler_q) + k) % NUM_BOWLERS);
      if (quota_q[cand] < QW'(MAX_OVERS_BOWLER)) begin
        nxt_ok = 1'b1;
        nxt_id = cand;
      end
    end
  end
  assign in_inn = (state_q == INN1) || (state_q == INN2);
  assign over_end = in_inn && delivery && (ball_q == 3'(BALLS_PER_OVER - 1));
  assign inn_end_overs = over_end && (over_q == 5'(MAX_OVERS - 1));
  assign toss_team = toss_winner ^ ~toss_choice;
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    team_d = team_q;
    play_d = in_inn && delivery;
    bowler_d = bowler_q;
    over_d = over_q;
    ball_d = (in_inn && delivery) ? (over_end ? 3'd0 : ball_q + 3'd1) : ball_q;
    brk_d = brk_q;
    done_d = done_q;
    err_d = err_q;
    cnt_d = cnt_q;
    quota_d = quota_q;
    // the closing over of a full innings needs no successor, so it must not raise sched_err
    if (over_end) begin
      over_d = over_q + 5'd1;
      quota_d[bowler_q] = quota_q[bowler_q] + QW'(1);
      bowler_d = (!inn_end_overs && nxt_ok) ? nxt_id : bowler_q;
      err_d = err_q | (!inn_end_overs && !nxt_ok);
    end
    case (state_q)
      IDLE: state_d = start ? TOSS : IDLE;
      TOSS: begin
        state_d = INN1;
        first_d = toss_team;
        team_d = toss_team;
        over_d = '0;
        ball_d = '0;
        bowler_d = '0;
        quota_d = '{default: '0};
      end
      INN1: begin
        state_d = game_over ? DONE : (innings_over || inn_end_overs) ? BRK : INN1;
        done_d = game_over;
        brk_d = !game_over && (innings_over || inn_end_overs);
        cnt_d = '0;
      end
      BRK: begin
        if (cnt_q == CW'(BREAK_CYCLES - 1)) begin
          state_d = INN2;
          brk_d = 1'b0;
          team_d = ~first_q;
          over_d = '0;
          ball_d = '0;
          bowler_d = '0;
          quota_d = '{default: '0};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      INN2: begin
        state_d = (game_over || innings_over || inn_end_overs) ? DONE : INN2;
        done_d = game_over || innings_over || inn_end_overs;
      end
      DONE: begin
        if (start) begin
          state_d = IDLE;
          done_d = 1'b0;
          team_d = 1'b0;
          over_d = '0;
          ball_d = '0;
          bowler_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      team_q <= 1'b0;
      play_q <= 1'b0;
      bowler_q <= '0;
      over_q <= '0;
      ball_q <= '0;
      brk_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      quota_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      team_q <= team_d;
      play_q <= play_d;
      bowler_q <= bowler_d;
      over_q <= over_d;
      ball_q <= ball_d;
      brk_q <= brk_d;
      done_q <= done_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      quota_q <= quota_d;
    end
  end
  assign team = team_q;
  assign play = play_q;
  assign bowler_id = bowler_q;
  assign over_num = over_q;
  assign ball_in_over = ball_q;
  assign innings_break = brk_q;
  assign match_done = done_q;
  assign sched_err = err_q;
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: vector table, directed match sequences and randomized play against a ball-count model
module tb_match_sequencer;
  localparam int BPO = 6;
  localparam int MAXO = 20;
  localparam int NB = 5;
  localparam int QUOTA = 4;
  localparam int BRKC = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, toss_winner = 1'b0, toss_choice = 1'b0;
  logic delivery = 1'b0, innings_over = 1'b0, game_over = 1'b0;
  logic team, play, innings_break, match_done, sched_err;
  logic [2:0] bowler_id, ball_in_over;
  logic [4:0] over_num;
  int total = 0, bad = 0;
  match_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .toss_winner(toss_winner), .toss_choice(toss_choice),
    .delivery(delivery), .innings_over(innings_over), .game_over(game_over),
    .team(team), .play(play), .bowler_id(bowler_id), .over_num(over_num),
    .ball_in_over(ball_in_over), .innings_break(innings_break), .match_done(match_done),
    .sched_err(sched_err)
  );
  always #5 clk = ~clk;
  // model: phase 0 idle, 1 toss, 2 first innings, 3 break, 4 second innings, 5 done
  int m_phase = 0, m_balls = 0, m_bowler = 0, m_brk_left = 0;
  bit m_first = 0, m_team = 0, m_play = 0, m_brk = 0, m_done = 0, m_err = 0;
  int m_quota [NB];
  task automatic new_innings();
    m_balls = 0;
    m_bowler = 0;
    for (int i = 0; i < NB; i++) m_quota[i] = 0;
  endtask
  task automatic pick_next();
    for (int k = 1; k < NB; k++) begin
      if (m_quota[(m_bowler + k) % NB] < QUOTA) begin
        m_bowler = (m_bowler + k) % NB;
        return;
      end
    end
    m_err = 1;
  endtask
  task automatic model_step();
    m_play = 0;
    if (rst) begin
      m_phase = 0; m_first = 0; m_team = 0; m_brk = 0; m_done = 0; m_err = 0;
      new_innings();
      return;
    end
    case (m_phase)
      0: if (start) m_phase = 1;
      1: begin
        m_first = toss_winner ^ !toss_choice;
        m_team = m_first;
        new_innings();
        m_phase = 2;
      end
      2, 4: begin
        if (delivery) begin
          m_play = 1;
          m_balls++;
          if (m_balls % BPO == 0) begin
            m_quota[m_bowler]++;
            if (m_balls != BPO * MAXO) pick_next();
          end
        end
        if (game_over) begin
          m_phase = 5; m_done = 1;
        end else if (innings_over || m_balls == BPO * MAXO) begin
          if (m_phase == 2) begin
            m_phase = 3; m_brk = 1; m_brk_left = BRKC;
          end else begin
            m_phase = 5; m_done = 1;
          end
        end
      end
      3: begin
        m_brk_left--;
        if (m_brk_left == 0) begin
          m_brk = 0; m_team = !m_first; m_phase = 4;
          new_innings();
        end
      end
      5: if (start) begin
        m_phase = 0; m_done = 0; m_team = 0;
        new_innings();
      end
      default: m_phase = 0;
    endcase
  endtask
  task automatic cyc(input logic s, input logic tw, input logic tc, input logic d, input logic io,
                     input logic go, input logic r);
    start = s; toss_winner = tw; toss_choice = tc; delivery = d;
    innings_over = io; game_over = go; rst = r;
    model_step();
    @(posedge clk);
    #1;
    start = 0; delivery = 0; innings_over = 0; game_over = 0; rst = 0;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_model();
    chk("m_team", team, m_team);
    chk("m_play", play, m_play);
    chk("m_bowler", bowler_id, m_bowler);
    chk("m_over", over_num, m_balls / BPO);
    chk("m_ball", ball_in_over, m_balls % BPO);
    chk("m_break", innings_break, m_brk);
    chk("m_done", match_done, m_done);
    chk("m_err", sched_err, m_err);
  endtask
  typedef struct {
    logic s, tw, tc, d, io, go;
    logic e_team, e_play;
    int e_bowler, e_over, e_ball;
    logic e_brk, e_done;
  } vec_t;
  vec_t tbl [12];
  int n;
  initial begin
    tbl[0]  = '{1,0,0,0,0,0, 0,0,0,0,0,0,0};
    tbl[1]  = '{0,1,0,0,0,0, 0,0,0,0,0,0,0};
    tbl[2]  = '{0,0,0,1,0,0, 0,1,0,0,1,0,0};
    tbl[3]  = '{0,0,0,1,0,0, 0,1,0,0,2,0,0};
    tbl[4]  = '{0,0,0,0,0,0, 0,0,0,0,2,0,0};
    tbl[5]  = '{0,0,0,1,0,0, 0,1,0,0,3,0,0};
    tbl[6]  = '{0,0,0,1,0,0, 0,1,0,0,4,0,0};
    tbl[7]  = '{0,0,0,1,0,0, 0,1,0,0,5,0,0};
    tbl[8]  = '{0,0,0,1,0,0, 0,1,1,1,0,0,0};
    tbl[9]  = '{0,0,0,0,0,0, 0,0,1,1,0,0,0};
    tbl[10] = '{0,0,0,1,1,0, 0,1,1,1,1,1,0};
    tbl[11] = '{0,0,0,1,0,0, 0,0,1,1,1,1,0};
    cyc(0,0,0,0,0,0,1);
    cyc(0,0,0,0,0,0,1);
    chk_model();
    chk("rst_play", play, 0);
    chk("rst_over", over_num, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].s, tbl[i].tw, tbl[i].tc, tbl[i].d, tbl[i].io, tbl[i].go, 0);
      chk($sformatf("v%0d_team", i), team, tbl[i].e_team);
      chk($sformatf("v%0d_play", i), play, tbl[i].e_play);
      chk($sformatf("v%0d_bowler", i), bowler_id, tbl[i].e_bowler);
      chk($sformatf("v%0d_over", i), over_num, tbl[i].e_over);
      chk($sformatf("v%0d_ball", i), ball_in_over, tbl[i].e_ball);
      chk($sformatf("v%0d_break", i), innings_break, tbl[i].e_brk);
      chk($sformatf("v%0d_done", i), match_done, tbl[i].e_done);
    end
    cyc(0,0,0,0,0,0,1);
    cyc(1,0,0,0,0,0,0);
    cyc(0,0,1,0,0,0,0);
    chk("full_team1", team, 0);
    for (int o = 0; o < MAXO; o++) begin
      chk($sformatf("rot_over%0d", o), bowler_id, o % NB);
      for (int b = 0; b < BPO; b++) cyc(0,0,0,1,0,0,0);
    end
    chk("full_over", over_num, MAXO);
    chk("full_ball", ball_in_over, 0);
    chk("full_break", innings_break, 1);
    chk("full_err", sched_err, 0);
    n = 0;
    while (innings_break && n < 40) begin
      cyc(0,0,0,1,0,0,0);
      chk("brk_noplay", play, 0);
      n++;
    end
    chk("brk_len", n, BRKC);
    chk("inn2_team", team, 1);
    chk("inn2_over", over_num, 0);
    chk("inn2_bowler", bowler_id, 0);
    cyc(0,0,0,1,0,0,0);
    cyc(0,0,0,1,0,0,0);
    cyc(0,0,0,1,0,1,0);
    chk("go_play", play, 1);
    chk("go_ball", ball_in_over, 3);
    chk("go_done", match_done, 1);
    cyc(0,0,0,1,0,0,0);
    chk("done_noplay", play, 0);
    chk("done_ball", ball_in_over, 3);
    chk("done_hold", match_done, 1);
    cyc(1,0,0,0,0,0,0);
    chk("idle_done", match_done, 0);
    cyc(1,0,0,0,0,0,0);
    cyc(0,1,1,0,0,0,0);
    chk("toss_team", team, 1);
    cyc(0,0,0,0,1,0,0);
    chk("io_break", innings_break, 1);
    for (int i = 0; i < BRKC; i++) cyc(0,0,0,0,0,0,0);
    chk("io_inn2_team", team, 0);
    chk("io_inn2_break", innings_break, 0);
    for (int i = 0; i < 7; i++) cyc(0,0,0,1,0,0,0);
    chk("pre_rst_bowler", bowler_id, 1);
    cyc(0,0,0,1,0,0,1);
    chk_model();
    chk("rst2_team", team, 0);
    chk("rst2_over", over_num, 0);
    cyc(1,0,0,0,0,0,0);
    cyc(0,1,0,0,0,0,0);
    for (int i = 0; i < 6; i++) cyc(0,0,0,1,0,0,0);
    chk("fresh_bowler", bowler_id, 1);
    chk("fresh_over", over_num, 1);
    chk("fresh_team", team, 0);
    for (int i = 0; i < 20000; i++) begin
      cyc($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0, $urandom_range(0, 599) == 0,
          $urandom_range(0, 2999) == 0);
      chk_model();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
